// File: rtl/wm_phase_timer.sv
// Phase timer for the washing-machine controller: times fill/heat/wash/rinse/spin
// and pulses sig_Time_Out or sig_Completed. Optional pause input under WM_PAUSE_EN.
module wm_phase_timer #(
  parameter int PRESCALE     = 1000,
  parameter int CNT_W        = 16,
  parameter int FILL_TIMEOUT = 120,
  parameter int HEAT_TIMEOUT = 300,
  parameter int WASH_TIME    = 600,
  parameter int RINSE_TIME   = 300,
  parameter int SPIN_TIME    = 180
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       state,
`ifdef WM_PAUSE_EN
  input  logic             pause,
`endif
  output logic             sig_Completed,
  output logic             sig_Time_Out,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  // state | meaning
  // IDLE  | controller in START/READY/FAULT, nothing timed
  // RUN   | timing the current phase
  // HOLD  | phase elapsed, waiting for the controller to move on
  typedef enum logic [1:0] {IDLE, RUN, HOLD} fsm_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam bit CFG_OK = (64'(FILL_TIMEOUT) <= CNT_MAX) && (64'(HEAT_TIMEOUT) <= CNT_MAX) &&
                          (64'(WASH_TIME) <= CNT_MAX) && (64'(RINSE_TIME) <= CNT_MAX) &&
                          (64'(SPIN_TIME) <= CNT_MAX);

  // A zero duration still runs one tick so the phase always produces its pulse.
  localparam logic [CNT_W-1:0] FILL_LD  = (FILL_TIMEOUT == 0) ? CNT_W'(1) : CNT_W'(FILL_TIMEOUT);
  localparam logic [CNT_W-1:0] HEAT_LD  = (HEAT_TIMEOUT == 0) ? CNT_W'(1) : CNT_W'(HEAT_TIMEOUT);
  localparam logic [CNT_W-1:0] WASH_LD  = (WASH_TIME == 0)    ? CNT_W'(1) : CNT_W'(WASH_TIME);
  localparam logic [CNT_W-1:0] RINSE_LD = (RINSE_TIME == 0)   ? CNT_W'(1) : CNT_W'(RINSE_TIME);
  localparam logic [CNT_W-1:0] SPIN_LD  = (SPIN_TIME == 0)    ? CNT_W'(1) : CNT_W'(SPIN_TIME);

  fsm_t             fsm;
  logic [2:0]       prev_state;
  logic [PW-1:0]    prescaler;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_val;
  logic             phase_change;
  logic             timed_phase;
  logic             frozen;
  logic             tick;

`ifdef WM_PAUSE_EN
  assign frozen = pause;
`else
  assign frozen = 1'b0;
`endif

  assign phase_change = (state != prev_state);
  assign timed_phase  = (state >= 3'd2) && (state <= 3'd6);
  assign tick         = (prescaler == PS_LAST) && !frozen;

  always_comb begin
    load_val = CNT_W'(1);
    case (state)
      3'd2:    load_val = FILL_LD;
      3'd3:    load_val = HEAT_LD;
      3'd4:    load_val = WASH_LD;
      3'd5:    load_val = RINSE_LD;
      3'd6:    load_val = SPIN_LD;
      default: load_val = CNT_W'(1);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_state    <= 3'd0;
      fsm           <= IDLE;
      prescaler     <= '0;
      count         <= '0;
      sig_Completed <= 1'b0;
      sig_Time_Out  <= 1'b0;
    end else begin
      assert (CFG_OK);
      prev_state    <= state;
      sig_Completed <= 1'b0;
      sig_Time_Out  <= 1'b0;
      if (phase_change) begin
        prescaler <= '0;
        if (timed_phase) begin
          fsm   <= RUN;
          count <= load_val;
        end else begin
          fsm   <= IDLE;
          count <= '0;
        end
      end else if (fsm == RUN && !frozen) begin
        if (tick) begin
          prescaler <= '0;
          if (count == CNT_W'(1)) begin
            count         <= '0;
            fsm           <= HOLD;
            sig_Time_Out  <= (state == 3'd2) || (state == 3'd3);
            sig_Completed <= (state >= 3'd4) && (state <= 3'd6);
          end else begin
            count <= count - CNT_W'(1);
          end
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end
    end
  end

  assign busy      = (fsm == RUN);
  assign remaining = (fsm == RUN) ? count : '0;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Scoreboard bench for wm_phase_timer: a cycle-level reference model predicts
// busy/remaining and queues each expected pulse; a monitor pops and checks pulses.
module tb_wm_phase_timer;
  localparam int P  = 4;
  localparam int CW = 8;
  localparam int FT = 5;
  localparam int HT = 2;
  localparam int WT = 3;
  localparam int RT = 1;
  localparam int ST = 0;
`ifdef WM_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pause = 1'b0;
  logic [2:0]    state = 3'd0;
  logic          sig_Completed, sig_Time_Out, busy;
  logic [CW-1:0] remaining;

  wm_phase_timer #(.PRESCALE(P), .CNT_W(CW), .FILL_TIMEOUT(FT), .HEAT_TIMEOUT(HT),
                   .WASH_TIME(WT), .RINSE_TIME(RT), .SPIN_TIME(ST)) dut (
    .clock(clk),
    .reset(reset),
    .state(state),
`ifdef WM_PAUSE_EN
    .pause(pause),
`endif
    .sig_Completed(sig_Completed),
    .sig_Time_Out(sig_Time_Out),
    .busy(busy),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct { int due; bit to; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit started = 1'b0;
  bit m_run = 1'b0;
  int m_left = 0;
  logic [2:0] m_prev = 3'd0;

  function automatic int dur_of(input logic [2:0] s);
    int d;
    case (s)
      3'd2: d = FT;
      3'd3: d = HT;
      3'd4: d = WT;
      3'd5: d = RT;
      default: d = ST;
    endcase
    return (d == 0) ? 1 : d;
  endfunction

  // Reference model: a phase lasts dur*P unpaused cycles counted from its load edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      started = 1'b1;
      m_prev  = 3'd0;
      m_run   = 1'b0;
      m_left  = 0;
      if (q.size() > 0) void'(q.pop_back());
    end else begin
      if (state != m_prev) begin
        if (q.size() > 0) void'(q.pop_back());
        if (state >= 3'd2 && state <= 3'd6) begin
          m_run  = 1'b1;
          m_left = dur_of(state) * P;
          q.push_back('{due: cyc + m_left, to: (state <= 3'd3)});
        end else begin
          m_run  = 1'b0;
          m_left = 0;
        end
      end else if (m_run) begin
        if (PAUSE_ON && pause) begin
          if (q.size() > 0) q[q.size()-1].due++;
        end else begin
          m_left--;
          if (m_left == 0) m_run = 1'b0;
        end
      end
      m_prev = state;
    end
  end

  initial forever begin
    int exp_rem;
    exp_t e;
    @(negedge clk);
    if (started) begin
      exp_rem = m_run ? (m_left + P - 1) / P : 0;
      total++;
      if (busy !== m_run) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, m_run);
      end
      total++;
      if (remaining !== CW'(exp_rem)) begin
        bad++;
        $display("FAIL remaining cyc=%0d got=%0d want=%0d", cyc, remaining, exp_rem);
      end
      if (sig_Completed === 1'b1 || sig_Time_Out === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse cyc=%0d got=%b%b want=00", cyc, sig_Completed, sig_Time_Out);
        end else begin
          e = q.pop_front();
          if (e.due != cyc || sig_Time_Out !== e.to || sig_Completed !== !e.to) begin
            bad++;
            $display("FAIL pulse cyc=%0d got(done,to)=%b%b want cyc=%0d to=%b",
                     cyc, sig_Completed, sig_Time_Out, e.due, e.to);
          end
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        total++;
        bad++;
        $display("FAIL missing_pulse cyc=%0d got=none want to=%b at cyc=%0d", cyc, q[0].to, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  task automatic drive(input bit r, input logic [2:0] s, input bit p, input int n);
    reset = r;
    state = s;
    pause = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held with state=4, then wash runs 12 cycles into HOLD
    drive(1'b1, 3'd4, 1'b0, 3);
    drive(1'b0, 3'd4, 1'b0, 16);
    // fill timeout
    drive(1'b0, 3'd0, 1'b0, 2);
    drive(1'b0, 3'd2, 1'b0, 24);
    // abort to FAULT mid-wash, then fresh load
    drive(1'b0, 3'd0, 1'b0, 2);
    drive(1'b0, 3'd4, 1'b0, 6);
    drive(1'b0, 3'd7, 1'b0, 2);
    drive(1'b0, 3'd1, 1'b0, 2);
    drive(1'b0, 3'd4, 1'b0, 15);
    // reset mid-run
    drive(1'b0, 3'd0, 1'b0, 2);
    drive(1'b0, 3'd4, 1'b0, 5);
    drive(1'b1, 3'd4, 1'b0, 1);
    drive(1'b0, 3'd4, 1'b0, 15);
    // phase change lands on the expiry edge: reload, no pulse
    drive(1'b0, 3'd0, 1'b0, 2);
    drive(1'b0, 3'd4, 1'b0, 12);
    drive(1'b0, 3'd5, 1'b0, 8);
    // zero-duration spin and short heat
    drive(1'b0, 3'd6, 1'b0, 6);
    drive(1'b0, 3'd3, 1'b0, 10);
    // pause mid-wash (ignored when the feature is absent)
    drive(1'b0, 3'd0, 1'b0, 2);
    drive(1'b0, 3'd4, 1'b0, 3);
    drive(1'b0, 3'd4, 1'b1, 7);
    drive(1'b0, 3'd4, 1'b0, 14);
    for (int i = 0; i < 300; i++) begin
      bit r;
      bit p;
      r = ($urandom_range(0, 24) == 0);
      p = ($urandom_range(0, 3) == 0);
      drive(r, 3'($urandom_range(0, 7)), p, r ? 1 : $urandom_range(1, 28));
    end
    drive(1'b0, 3'd0, 1'b0, 3);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
